pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Sequencing controller for the decode stage of the pipeline. Each cycle it checks the instruction held in the IF/ID buffer against a per-register scoreboard of pending writes. It produces the enables for the entry (IF/ID) and decode (ID/EX) buffers, and it inserts bubbles into ID/EX. It also serialises multi-cycle divides and flushes the front end after a taken branch. It sits between the entry buffer, the decode block and the execute/writeback stages.

## Interface
Parameters:
- `NUM_REGS`, 16: architectural registers tracked by the scoreboard.
- `DIV_CYCLES`, 8: execute occupancy of a divide, in cycles (≥2).
- `FLUSH_DEPTH`, 2: cycles issue stays suppressed after a taken branch (≥1).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the IF/ID buffer holds a real instruction.
- `id_type` input 5: instruction class field.
- `id_opcode` input 4: opcode field.
- `id_ra`, `id_rb`, `id_rd` input 4 each: source A, source B and destination register fields.
- `br_resolved` input 1: execute has resolved the in-flight branch this cycle.
- `br_taken` input 1: qualifies `br_resolved`; the branch is taken.
- `wb_we` input 1: writeback is retiring a register write this cycle.
- `wb_rd` input 4: destination register of that writeback.
- `if_en` output 1: enable for the PC and the IF/ID entry buffer.
- `id_en` output 1: enable for the ID/EX buffer.
- `ex_bubble` output 1: force NOP (type 00000) into ID/EX.
- `flush` output 1: clear the IF/ID buffer.
- `busy_mask` output NUM_REGS: scoreboard, one bit per register.
- `state` output 2: current FSM state, for debug.

## Operation
- Class decode (functions in the package):
  - ALU_REG 00001: reads Ra and Rb, writes Rd.
  - ALU_IMM 10001: reads Ra, writes Rd.
  - LOAD 00011: reads Ra and Rb, writes Rd.
  - STORE 00111: reads Ra, Rb and Rd; writes nothing.
  - BRANCH 11000: reads nothing, writes nothing.
  - NOP 00000, and any unlisted type: no reads, no writes, never hazardous.
- Source hazard: a source register whose `busy_mask` bit is set. A source equal to `wb_rd` while `wb_we`=1 counts as ready (same-cycle bypass).
- Issue: `id_valid` AND state RUN AND no source hazard. All other cycles are stalls.
- Stall: `if_en`=0, `id_en`=1, `ex_bubble`=1.
- Issue cycle: `if_en`=1, `id_en`=1, `ex_bubble`=0.
- No valid instruction, in RUN: `if_en`=1, `id_en`=1, `ex_bubble`=1.
- Scoreboard update at each rising edge:
  - Clear bit `wb_rd` if `wb_we`.
  - Set bit `id_rd` if the instruction issued and its class writes Rd.
  - Same register set and cleared in one cycle: the set wins.
- FSM:
  - RUN (00)
    - → DIV (01) on issue of ALU_REG or ALU_IMM with opcode 0101; counter loads DIV_CYCLES-1.
    - → BRW (10) on issue of BRANCH.
  - DIV: counter decrements each cycle; → RUN when counter reaches 0. No issue while in DIV.
  - BRW: waits for `br_resolved`. No issue while in BRW.
    - `br_taken`=1: `flush` pulses, counter loads FLUSH_DEPTH-1, → FLS (11).
    - `br_taken`=0: → RUN.
  - FLS: `if_en`=1 (fetch the target), `ex_bubble`=1. Counter decrements; → RUN at 0.
- `br_resolved` outside BRW is ignored.
- Writebacks are processed in every state.
- Reset (async, any state, mid-divide or mid-flush):
  - state=RUN, counter=0, `busy_mask`=0, `flush`=0.
  - While `rst`=0: `if_en`=0, `id_en`=0, `ex_bubble`=1.

## Timing
- `if_en`, `id_en`, `ex_bubble`: combinational from state, scoreboard and ID/WB inputs, within the same cycle.
- `flush`: registered. High for exactly one cycle, the cycle after the `br_resolved`/`br_taken` sample.
- `busy_mask` and `state`: registered; they reflect a change one edge after its cause.
- Load-use pair: the dependent instruction stalls until the writeback cycle of the load, then issues in that same cycle via the bypass.
- Divide: the instruction after a divide issues no earlier than DIV_CYCLES+1 cycles after the divide.
- Taken branch: exactly FLUSH_DEPTH bubble cycles after the flush pulse, then RUN.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - The type codes (TYPE_NOP, TYPE_ALU_REG, TYPE_ALU_IMM, TYPE_LOAD, TYPE_STORE, TYPE_BRANCH).
  - OPC_DIV = 4'b0101.
  - A state enum (RUN, DIV, BRW, FLS).
  - Functions `reads_ra`, `reads_rb`, `reads_rd` and `writes_rd`.
- Sub-module `reg_scoreboard` holds the busy bits, the set/clear logic with set priority, and the bypass-aware hazard check.
- The FSM and down-counter live in the top module.

## Test plan
- Reset mid-divide: state=DIV, counter=5, `busy_mask`=0x0400, then `rst`=0 → immediately state=RUN, `busy_mask`=0, `flush`=0, `ex_bubble`=1.
- `ld r15,[r0+r4]`, then `add r3,r15,r1` → r15 busy; the add stalls (`if_en`=0, `ex_bubble`=1) until `wb_we`=1 with `wb_rd`=15, and issues in that cycle.
- `div r10,r6,#15` issues → state=DIV; the following `not r1,r10` is held for 8 cycles; `busy_mask` bit 10 is set until the writeback of r10.
- `bg #26` issues, then `br_resolved`=1, `br_taken`=1 → `flush`=1 for one cycle, then 2 cycles of bubbles with `if_en`=1, then RUN.
- Same branch with `br_taken`=0 → no flush; RUN on the next edge.
- `wb_we`=1 with `wb_rd`=3 while `add r3,...` issues → bit 3 remains set.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the decode-stage hazard controller:
//   - instruction class codes and the divide opcode
//   - controller FSM state encoding
//   - class decode helpers telling which register fields an instruction
//     reads and whether it writes its destination
package pipeline_ctrl_pkg;

  localparam logic [4:0] TYPE_NOP     = 5'b00000;
  localparam logic [4:0] TYPE_ALU_REG = 5'b00001;
  localparam logic [4:0] TYPE_ALU_IMM = 5'b10001;
  localparam logic [4:0] TYPE_LOAD    = 5'b00011;
  localparam logic [4:0] TYPE_STORE   = 5'b00111;
  localparam logic [4:0] TYPE_BRANCH  = 5'b11000;

  localparam logic [3:0] OPC_DIV = 4'b0101;

  typedef enum logic [1:0] {
    RUN = 2'b00,
    DIV = 2'b01,
    BRW = 2'b10,
    FLS = 2'b11
  } ctrl_state_e;

  function automatic logic reads_ra(input logic [4:0] t);
    logic r;
    case (t)
      TYPE_ALU_REG, TYPE_ALU_IMM, TYPE_LOAD, TYPE_STORE: r = 1'b1;
      default:                                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_rb(input logic [4:0] t);
    logic r;
    case (t)
      TYPE_ALU_REG, TYPE_LOAD, TYPE_STORE: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // Only a store uses its Rd field as a source (the data to be stored).
  function automatic logic reads_rd(input logic [4:0] t);
    logic r;
    case (t)
      TYPE_STORE: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic writes_rd(input logic [4:0] t);
    logic r;
    case (t)
      TYPE_ALU_REG, TYPE_ALU_IMM, TYPE_LOAD: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Divides are ALU operations (register or immediate form) with OPC_DIV.
  function automatic logic is_div(input logic [4:0] t, input logic [3:0] op);
    logic r;
    case (t)
      TYPE_ALU_REG, TYPE_ALU_IMM: r = (op == OPC_DIV);
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// reg_scoreboard
// One busy bit per architectural register, marking a pending write.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ra, rb, rd               register fields of the instruction in IF/ID
//   use_ra, use_rb, use_rd   which of those fields are sources
//   set_en, set_idx          mark a register busy (issued writer)
//   clr_en, clr_idx          retire a register write (writeback)
//   hazard                   some used source is busy and not bypassed
//   busy_mask                registered busy bits
module reg_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rd,
  input  logic                use_ra,
  input  logic                use_rb,
  input  logic                use_rd,
  input  logic                set_en,
  input  logic [3:0]          set_idx,
  input  logic                clr_en,
  input  logic [3:0]          clr_idx,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec_s;
  logic [NUM_REGS-1:0] clr_vec_s;
  logic                haz_a_s;
  logic                haz_b_s;
  logic                haz_d_s;

  // A source being retired by writeback this cycle is forwarded, so it is ready.
  function automatic logic src_busy(input logic [NUM_REGS-1:0] busy,
                                    input logic [3:0] src,
                                    input logic byp_en,
                                    input logic [3:0] byp_idx);
    return busy[src] && !(byp_en && (byp_idx == src));
  endfunction

  assign haz_a_s = use_ra && src_busy(busy_q, ra, clr_en, clr_idx);
  assign haz_b_s = use_rb && src_busy(busy_q, rb, clr_en, clr_idx);
  assign haz_d_s = use_rd && src_busy(busy_q, rd, clr_en, clr_idx);
  assign hazard  = haz_a_s || haz_b_s || haz_d_s;

  // Next busy bits: clear the retired register, then OR in the new writer so
  // a register cleared and set in the same cycle stays busy.
  always_comb begin
    set_vec_s = set_en ? (ONE_HOT0 << set_idx) : {NUM_REGS{1'b0}};
    clr_vec_s = clr_en ? (ONE_HOT0 << clr_idx) : {NUM_REGS{1'b0}};
    busy_d    = (busy_q & ~clr_vec_s) | set_vec_s;
  end

  // Busy-bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Decode-stage sequencing: checks the IF/ID instruction against the register
// scoreboard, drives the IF/ID and ID/EX enables, injects bubbles, holds issue
// during a multi-cycle divide and flushes the front end after a taken branch.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   id_valid, id_type, id_opcode  instruction in IF/ID
//   id_ra, id_rb, id_rd           its register fields
//   br_resolved, br_taken         branch outcome from execute
//   wb_we, wb_rd                  register write retiring in writeback
//   if_en, id_en, ex_bubble       buffer enables / NOP injection (combinational)
//   flush                         one-cycle IF/ID clear (registered)
//   busy_mask, state              scoreboard and FSM state (registered)
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int DIV_CYCLES  = 8,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_type,
  input  logic [3:0]          id_opcode,
  input  logic [3:0]          id_ra,
  input  logic [3:0]          id_rb,
  input  logic [3:0]          id_rd,
  input  logic                br_resolved,
  input  logic                br_taken,
  input  logic                wb_we,
  input  logic [3:0]          wb_rd,
  output logic                if_en,
  output logic                id_en,
  output logic                ex_bubble,
  output logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [1:0]          state
);

  localparam int CNT_MAX = (DIV_CYCLES > FLUSH_DEPTH) ? DIV_CYCLES : FLUSH_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLS_LOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flush_q;
  logic             flush_d;
  logic             hazard_s;
  logic             issue_s;
  logic             set_en_s;

  assign issue_s  = id_valid && (state_q == RUN) && !hazard_s;
  assign set_en_s = issue_s && writes_rd(id_type);

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .ra        (id_ra),
    .rb        (id_rb),
    .rd        (id_rd),
    .use_ra    (reads_ra(id_type)),
    .use_rb    (reads_rb(id_type)),
    .use_rd    (reads_rd(id_type)),
    .set_en    (set_en_s),
    .set_idx   (id_rd),
    .clr_en    (wb_we),
    .clr_idx   (wb_rd),
    .hazard    (hazard_s),
    .busy_mask (busy_mask)
  );

  // Next-state, down-counter and flush-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    case (state_q)
      RUN: begin
        if (issue_s && is_div(id_type, id_opcode)) begin
          state_d = DIV;
          cnt_d   = DIV_LOAD;
        end else if (issue_s && (id_type == TYPE_BRANCH)) begin
          state_d = BRW;
        end else begin
          state_d = RUN;
        end
      end
      DIV: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BRW: begin
        if (br_resolved && br_taken) begin
          state_d = FLS;
          cnt_d   = FLS_LOAD;
          flush_d = 1'b1;
        end else if (br_resolved) begin
          state_d = RUN;
        end else begin
          state_d = BRW;
        end
      end
      FLS: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Buffer enables. FLS keeps fetching (the branch target) while ID/EX gets NOPs;
  // reset forces both buffers off regardless of state.
  always_comb begin
    if_en     = 1'b0;
    id_en     = 1'b1;
    ex_bubble = 1'b1;
    if (!rst) begin
      id_en = 1'b0;
    end else if (issue_s) begin
      if_en     = 1'b1;
      ex_bubble = 1'b0;
    end else if (((state_q == RUN) && !id_valid) || (state_q == FLS)) begin
      if_en = 1'b1;
    end else begin
      if_en = 1'b0;
    end
  end

  // State, counter and flush registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= CNT_ZERO;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign flush = flush_q;
  assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: each step drives one cycle of
// inputs, queues the expected outputs for that cycle and checks them before the
// next rising edge.
module tb_pipeline_hazard_controller;

  localparam logic [4:0] T_NOP = 5'b00000;
  localparam logic [4:0] T_ALU = 5'b00001;
  localparam logic [4:0] T_IMM = 5'b10001;
  localparam logic [4:0] T_LD  = 5'b00011;
  localparam logic [4:0] T_ST  = 5'b00111;
  localparam logic [4:0] T_BR  = 5'b11000;
  localparam logic [4:0] T_ODD = 5'b01010;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_type;
  logic [3:0]  id_opcode;
  logic [3:0]  id_ra;
  logic [3:0]  id_rb;
  logic [3:0]  id_rd;
  logic        br_resolved;
  logic        br_taken;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic        if_en;
  logic        id_en;
  logic        ex_bubble;
  logic        flush;
  logic [15:0] busy_mask;
  logic [1:0]  state;

  pipeline_hazard_controller dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_type     (id_type),
    .id_opcode   (id_opcode),
    .id_ra       (id_ra),
    .id_rb       (id_rb),
    .id_rd       (id_rd),
    .br_resolved (br_resolved),
    .br_taken    (br_taken),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .if_en       (if_en),
    .id_en       (id_en),
    .ex_bubble   (ex_bubble),
    .flush       (flush),
    .busy_mask   (busy_mask),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        e_if;
    logic        e_id;
    logic        e_bub;
    logic        e_fl;
    logic [1:0]  e_st;
    logic [15:0] e_busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check1(input string tag, input string what,
                        input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check at posedge+4, then advance one edge.
  task automatic cyc(input string tag, input logic r, input logic v,
                     input logic [4:0] ty, input logic [3:0] op,
                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                     input logic brr, input logic brt,
                     input logic we, input logic [3:0] wrd,
                     input logic e_if, input logic e_id, input logic e_bub, input logic e_fl,
                     input logic [1:0] e_st, input logic [15:0] e_busy);
    exp_t e;
    rst = r; id_valid = v; id_type = ty; id_opcode = op;
    id_ra = a; id_rb = b; id_rd = d;
    br_resolved = brr; br_taken = brt; wb_we = we; wb_rd = wrd;
    e.tag = tag; e.e_if = e_if; e.e_id = e_id; e.e_bub = e_bub;
    e.e_fl = e_fl; e.e_st = e_st; e.e_busy = e_busy;
    exp_q.push_back(e);
    #3;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check1(e.tag, "if_en",     16'(if_en),     16'(e.e_if));
      check1(e.tag, "id_en",     16'(id_en),     16'(e.e_id));
      check1(e.tag, "ex_bubble", 16'(ex_bubble), 16'(e.e_bub));
      check1(e.tag, "flush",     16'(flush),     16'(e.e_fl));
      check1(e.tag, "state",     16'(state),     16'(e.e_st));
      check1(e.tag, "busy_mask", busy_mask,      e.e_busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_type = T_NOP; id_opcode = OP_ADD;
    id_ra = 4'd0; id_rb = 4'd0; id_rd = 4'd0;
    br_resolved = 1'b0; br_taken = 1'b0; wb_we = 1'b0; wb_rd = 4'd0;
    #1;
    //   tag              r     v     type   op      ra     rb     rd     brr   brt   we    wrd     if    id    bub   fl    st     busy
    cyc("reset",         1'b0, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000);
    cyc("idle",          1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000);
    // load-use pair, bypass on the writeback cycle
    cyc("ld_r15",        1'b1, 1'b1, T_LD,  OP_ADD, 4'd0,  4'd4,  4'd15, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("add_stall0",    1'b1, 1'b1, T_ALU, OP_ADD, 4'd15, 4'd1,  4'd3,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h8000);
    cyc("add_stall1",    1'b1, 1'b1, T_ALU, OP_ADD, 4'd15, 4'd1,  4'd3,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h8000);
    cyc("add_bypass",    1'b1, 1'b1, T_ALU, OP_ADD, 4'd15, 4'd1,  4'd3,  1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h8000);
    // set beats clear on the same register
    cyc("add_r3_wb3",    1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd3,  1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0008);
    cyc("wb_r3",         1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0008);
    // store reads its Rd field
    cyc("imm_r5",        1'b1, 1'b1, T_IMM, OP_ADD, 4'd0,  4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("st_stall",      1'b1, 1'b1, T_ST,  OP_ADD, 4'd1,  4'd2,  4'd5,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0020);
    cyc("st_bypass",     1'b1, 1'b1, T_ST,  OP_ADD, 4'd1,  4'd2,  4'd5,  1'b0, 1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0020);
    // immediate form ignores Rb; unlisted type is never hazardous
    cyc("ld_r7",         1'b1, 1'b1, T_LD,  OP_ADD, 4'd1,  4'd2,  4'd7,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("imm_rb_busy",   1'b1, 1'b1, T_IMM, OP_ADD, 4'd0,  4'd7,  4'd2,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0080);
    cyc("odd_type",      1'b1, 1'b1, T_ODD, OP_DIV, 4'd7,  4'd7,  4'd2,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0084);
    cyc("wb_r7",         1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0084);
    cyc("wb_r2",         1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0004);
    // div r10,r6,#15: the following not r1,r10 is held 8 cycles
    cyc("div_r10",       1'b1, 1'b1, T_IMM, OP_DIV, 4'd6,  4'd15, 4'd10, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      // a stray branch resolve in DIV is ignored; r10 retires in the last DIV cycle
      cyc("div_hold",    1'b1, 1'b1, T_ALU, OP_NOT, 4'd10, 4'd0,  4'd1,  (i == 2), (i == 2), (i == 7), 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0400);
    end
    cyc("not_issue",     1'b1, 1'b1, T_ALU, OP_NOT, 4'd10, 4'd0,  4'd1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("wb_r1",         1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0002);
    // taken branch: flush pulse, FLUSH_DEPTH fetching bubble cycles, then RUN
    cyc("bg_taken",      1'b1, 1'b1, T_BR,  OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("brw_wait",      1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0000);
    cyc("brw_resolve",   1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0000);
    cyc("fls0",          1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 16'h0000);
    cyc("fls1",          1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 16'h0000);
    cyc("post_flush",    1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    // not-taken branch: no flush, back to RUN on the next edge
    cyc("bg_nt",         1'b1, 1'b1, T_BR,  OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0010);
    cyc("brw_nt",        1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0000);
    cyc("post_nt",       1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("wb_r4",         1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0010);
    // reset mid-divide (counter at 5, r10 busy)
    cyc("div_alu",       1'b1, 1'b1, T_ALU, OP_DIV, 4'd6,  4'd6,  4'd10, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("div_c7",        1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0400);
    cyc("div_c6",        1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0400);
    cyc("rst_mid_div",   1'b0, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000);
    cyc("post_rst",      1'b1, 1'b1, T_ALU, OP_ADD, 4'd1,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("wb_r4b",        1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0010);
    // reset while the flush pulse is high
    cyc("bg2",           1'b1, 1'b1, T_BR,  OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cyc("brw2_res",      1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0000);
    cyc("rst_mid_fls",   1'b0, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000);
    cyc("after_rst",     1'b1, 1'b0, T_NOP, OP_ADD, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
